// File: rtl/hpdcache_pkg.sv
`default_nettype none
// =====================================================================
// Package : hpdcache_pkg
// Brief   : HPDcache request/response types shared by the prefetch path.
// Revision: 1.0
// =====================================================================
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_PA_WIDTH           = 40;
    localparam int unsigned HPDCACHE_WORD_WIDTH         = 64;
    localparam int unsigned HPDCACHE_REQ_TRANS_ID_WIDTH = 6;

    typedef logic [HPDCACHE_REQ_TRANS_ID_WIDTH-1:0] hpdcache_req_tid_t;

    typedef struct packed {
        logic [HPDCACHE_PA_WIDTH-1:0] addr;
        logic [3:0]                   op;
        logic [2:0]                   size;
        logic                         need_rsp;
        hpdcache_req_tid_t            tid;
    } hpdcache_req_t;

    typedef struct packed {
        logic [HPDCACHE_WORD_WIDTH-1:0] rdata;
        hpdcache_req_tid_t              tid;
        logic                           error;
    } hpdcache_rsp_t;

endpackage
`default_nettype wire

// File: rtl/hwpf_stride_pkg.sv
`default_nettype none
// =====================================================================
// Package : hwpf_stride_pkg
// Brief   : Engine-id type and limits for the stride prefetcher array.
// Revision: 1.0
// =====================================================================
package hwpf_stride_pkg;

    localparam int unsigned HWPF_STRIDE_MAX_ENGINES = 16;

    typedef logic [3:0] hwpf_engine_id_t;

    // Next engine index, wrapping at n (n need not be a power of two).
    function automatic hwpf_engine_id_t hwpf_wrap_inc(input hwpf_engine_id_t id,
                                                      input int unsigned     n);
        if ((32'(id) + 32'd1) >= n) begin
            return '0;
        end
        return id + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hwpf_stride_rr_arb.sv
`default_nettype none
// =====================================================================
// Module  : hwpf_stride_rr_arb
// Brief   : N-input round-robin arbiter, one-hot grant, pointer moves on accept.
// Revision: 1.0
// =====================================================================
module hwpf_stride_rr_arb
    import hwpf_stride_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic                 accept_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output hwpf_engine_id_t      gnt_idx_o,
    output logic                 gnt_valid_o
);

    hwpf_engine_id_t ptr_q, ptr_d;
    hwpf_engine_id_t lo_idx, hi_idx;
    logic            lo_v, hi_v;

    // Scan downwards so the last hit is the lowest index: lo_* is the
    // lowest requester overall, hi_* the lowest one at or above the pointer.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        lo_v   = 1'b0;
        hi_v   = 1'b0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_v   = 1'b1;
                lo_idx = hwpf_engine_id_t'(i);
                if (i >= int'(ptr_q)) begin
                    hi_v   = 1'b1;
                    hi_idx = hwpf_engine_id_t'(i);
                end
            end
        end
    end

    assign gnt_valid_o = lo_v;
    assign gnt_idx_o   = hi_v ? hi_idx : lo_idx;

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_gnt
        assign gnt_o[g] = gnt_valid_o && (gnt_idx_o == hwpf_engine_id_t'(g));
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && gnt_valid_o) begin
            ptr_d = hwpf_wrap_inc(gnt_idx_o, NUM_REQ);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hwpf_stride_arb.sv
`default_nettype none
// =====================================================================
// Module  : hwpf_stride_arb
// Brief   : Shares one HPDcache prefetch port among stride engines (RR, tid routing).
// Revision: 1.0
// =====================================================================
module hwpf_stride_arb
    import hpdcache_pkg::*;
    import hwpf_stride_pkg::*;
#(
    parameter int unsigned NUM_ENGINES  = 4,
    parameter int unsigned MAX_INFLIGHT = 0,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_ENGINES-1:0]  engine_req_valid_i,
    output logic [NUM_ENGINES-1:0]  engine_req_ready_o,
    input  hpdcache_req_t           engine_req_i [NUM_ENGINES],
    output logic [NUM_ENGINES-1:0]  engine_rsp_valid_o,
    output hpdcache_rsp_t           engine_rsp_o,
    output logic                    hpdcache_req_valid_o,
    input  logic                    hpdcache_req_ready_i,
    output hpdcache_req_t           hpdcache_req_o,
    input  logic                    hpdcache_rsp_valid_i,
    input  hpdcache_rsp_t           hpdcache_rsp_i,
    output logic                    busy_o,
    output logic                    rsp_tid_err_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    if ($clog2(NUM_ENGINES) > HPDCACHE_REQ_TRANS_ID_WIDTH) begin : g_chk_tid
        $error("hwpf_stride_arb: engine index does not fit in the request tid");
    end
    if ((NUM_ENGINES < 1) || (NUM_ENGINES > HWPF_STRIDE_MAX_ENGINES)) begin : g_chk_num
        $error("hwpf_stride_arb: NUM_ENGINES out of range");
    end
    if (64'(MAX_INFLIGHT) >= (64'd1 << CNT_WIDTH)) begin : g_chk_max
        $error("hwpf_stride_arb: MAX_INFLIGHT not representable in CNT_WIDTH");
    end

    logic                    obuf_valid_q, obuf_valid_d;
    hpdcache_req_t           obuf_q, obuf_d;
    hpdcache_req_t           sel_req;
    logic                    load_en;
    logic                    accept;
    logic [NUM_ENGINES-1:0]  eligible;
    logic [NUM_ENGINES-1:0]  gnt;
    hwpf_engine_id_t         gnt_idx;
    logic                    gnt_valid;
    logic [NUM_ENGINES-1:0]  cnt_nz;
    logic                    rsp_tid_in_range;
    logic                    tid_err_q, tid_err_d;

    // The buffer can take a new request when it is empty or draining this cycle.
    assign load_en = !obuf_valid_q || hpdcache_req_ready_i;
    assign accept  = load_en && gnt_valid;

    hwpf_stride_rr_arb #(
        .NUM_REQ     (NUM_ENGINES)
    ) u_rr_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (eligible),
        .accept_i    (load_en),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign engine_req_ready_o = gnt & {NUM_ENGINES{load_en}};

    assign rsp_tid_in_range = 32'(hpdcache_rsp_i.tid) < NUM_ENGINES;
    assign engine_rsp_o     = hpdcache_rsp_i;

    for (genvar i = 0; i < int'(NUM_ENGINES); i++) begin : g_eng
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 inc, dec;

        assign engine_rsp_valid_o[i] = hpdcache_rsp_valid_i
                                     && (32'(hpdcache_rsp_i.tid) == 32'(i));

        assign inc       = accept && gnt[i];
        assign dec       = engine_rsp_valid_o[i] && (cnt_q != '0);
        assign cnt_nz[i] = (cnt_q != '0);

        if (MAX_INFLIGHT == 0) begin : g_nolim
            assign eligible[i] = engine_req_valid_i[i];
        end else begin : g_lim
            assign eligible[i] = engine_req_valid_i[i]
                               && (cnt_q < CNT_WIDTH'(MAX_INFLIGHT));
        end

        // A same-cycle issue and completion cancel out.
        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end else if (dec && !inc) begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Forwarded request carries the granting engine's index as its tid.
    always_comb begin
        sel_req = '0;
        for (int i = 0; i < int'(NUM_ENGINES); i++) begin
            if (gnt[i]) begin
                sel_req = engine_req_i[i];
            end
        end
        sel_req.tid = hpdcache_req_tid_t'(gnt_idx);
    end

    always_comb begin
        obuf_valid_d = obuf_valid_q;
        obuf_d       = obuf_q;
        if (load_en) begin
            obuf_valid_d = gnt_valid;
            if (gnt_valid) begin
                obuf_d = sel_req;
            end
        end
    end

    assign tid_err_d = hpdcache_rsp_valid_i && !rsp_tid_in_range;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            obuf_valid_q <= 1'b0;
            obuf_q       <= '0;
            tid_err_q    <= 1'b0;
        end else begin
            obuf_valid_q <= obuf_valid_d;
            obuf_q       <= obuf_d;
            tid_err_q    <= tid_err_d;
        end
    end

    assign hpdcache_req_valid_o = obuf_valid_q;
    assign hpdcache_req_o       = obuf_q;
    assign busy_o               = obuf_valid_q || (|cnt_nz);
    assign rsp_tid_err_o        = tid_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hwpf_stride_arb.sv
`default_nettype none
// =====================================================================
// Module  : tb_hwpf_stride_arb
// Brief   : Directed table plus randomized traffic against a queue-level model.
// Revision: 1.0
// =====================================================================
module tb_hwpf_stride_arb;
    import hpdcache_pkg::*;

    localparam int NE   = 4;
    localparam int MAXI = 2;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk;
    logic            rst_ni;
    logic [NE-1:0]   engine_req_valid_i;
    logic [NE-1:0]   engine_req_ready_o;
    hpdcache_req_t   ereq_drv [NE];
    hpdcache_req_t   ereq_next [NE];
    logic [NE-1:0]   engine_rsp_valid_o;
    hpdcache_rsp_t   engine_rsp_o;
    logic            hpdcache_req_valid_o;
    logic            hpdcache_req_ready_i;
    hpdcache_req_t   hpdcache_req_o;
    logic            hpdcache_rsp_valid_i;
    hpdcache_rsp_t   hpdcache_rsp_i;
    logic            busy_o;
    logic            rsp_tid_err_o;

    hwpf_stride_arb #(
        .NUM_ENGINES  (NE),
        .MAX_INFLIGHT (MAXI),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .engine_req_valid_i   (engine_req_valid_i),
        .engine_req_ready_o   (engine_req_ready_o),
        .engine_req_i         (ereq_drv),
        .engine_rsp_valid_o   (engine_rsp_valid_o),
        .engine_rsp_o         (engine_rsp_o),
        .hpdcache_req_valid_o (hpdcache_req_valid_o),
        .hpdcache_req_ready_i (hpdcache_req_ready_i),
        .hpdcache_req_o       (hpdcache_req_o),
        .hpdcache_rsp_valid_i (hpdcache_rsp_valid_i),
        .hpdcache_rsp_i       (hpdcache_rsp_i),
        .busy_o               (busy_o),
        .rsp_tid_err_o        (rsp_tid_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model: occupancy per engine, next-preferred engine, one buffer slot.
    int            m_cnt [NE];
    int            m_rr;
    bit            m_ov;
    hpdcache_req_t m_ob;
    bit            m_err;
    int            m_grant;
    bit            m_load;
    bit            cur_rv;
    int            cur_tid;
    logic [NE-1:0] acc;

    typedef struct {
        logic [3:0] ev;   bit rdy;  bit rv;  logic [5:0] rtid;
        logic [3:0] erdy; bit qv;   logic [5:0] qtid;
        logic [3:0] ersp; bit busy; bit err;
    } vec_t;
    vec_t tbl [37];

    function automatic vec_t v(input logic [3:0] ev, input bit rdy, input bit rv, input int rtid,
                               input logic [3:0] erdy, input bit qv, input int qtid,
                               input logic [3:0] ersp, input bit busy, input bit err);
        vec_t r;
        r.ev = ev; r.rdy = rdy; r.rv = rv; r.rtid = 6'(rtid);
        r.erdy = erdy; r.qv = qv; r.qtid = 6'(qtid);
        r.ersp = ersp; r.busy = busy; r.err = err;
        return r;
    endfunction

    function automatic hpdcache_req_t rand_req();
        hpdcache_req_t r;
        r.addr     = {8'($urandom), $urandom};
        r.op       = 4'($urandom);
        r.size     = 3'($urandom);
        r.need_rsp = 1'($urandom);
        r.tid      = 6'($urandom);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) m_cnt[i] = 0;
        m_rr  = 0;
        m_ov  = 1'b0;
        m_ob  = '0;
        m_err = 1'b0;
    endtask

    task automatic drive_and_check(input logic [NE-1:0] ev, input bit rdy,
                                   input bit rv, input logic [5:0] rtid);
        logic [NE-1:0] e_erdy;
        logic [NE-1:0] e_ersp;
        bit            e_busy;
        @(negedge clk);
        for (int i = 0; i < NE; i++) ereq_drv[i] = ereq_next[i];
        engine_req_valid_i   = ev;
        hpdcache_req_ready_i = rdy;
        hpdcache_rsp_valid_i = rv;
        hpdcache_rsp_i.rdata = {$urandom, $urandom};
        hpdcache_rsp_i.tid   = rtid;
        hpdcache_rsp_i.error = 1'($urandom);
        #2;
        cur_rv  = rv;
        cur_tid = int'(rtid);
        m_load  = !m_ov || rdy;
        m_grant = -1;
        for (int k = 0; k < NE; k++) begin
            int e;
            e = (m_rr + k) % NE;
            if (m_grant < 0 && ev[e] && (MAXI == 0 || m_cnt[e] < MAXI)) m_grant = e;
        end
        e_erdy = '0;
        if (m_grant >= 0 && m_load) e_erdy[m_grant] = 1'b1;
        e_ersp = '0;
        if (rv && cur_tid < NE) e_ersp[cur_tid] = 1'b1;
        e_busy = m_ov;
        for (int i = 0; i < NE; i++) if (m_cnt[i] != 0) e_busy = 1'b1;
        chk("engine_req_ready", 64'(engine_req_ready_o), 64'(e_erdy));
        chk("engine_rsp_valid", 64'(engine_rsp_valid_o), 64'(e_ersp));
        chk("engine_rsp_data", 64'(engine_rsp_o.rdata) ^ 64'(engine_rsp_o.tid),
            64'(hpdcache_rsp_i.rdata) ^ 64'(hpdcache_rsp_i.tid));
        chk("req_valid", 64'(hpdcache_req_valid_o), 64'(m_ov));
        if (m_ov) chk("req_payload", 64'(hpdcache_req_o), 64'(m_ob));
        chk("busy", 64'(busy_o), 64'(e_busy));
        chk("tid_err", 64'(rsp_tid_err_o), 64'(m_err));
        acc = engine_req_ready_o;
    endtask

    task automatic commit();
        int inc;
        int dec;
        inc = (m_load && m_grant >= 0) ? m_grant : -1;
        dec = (cur_rv && cur_tid < NE && m_cnt[cur_tid] > 0) ? cur_tid : -1;
        if (m_load) begin
            if (m_grant >= 0) begin
                m_ob     = ereq_drv[m_grant];
                m_ob.tid = 6'(m_grant);
                m_ov     = 1'b1;
                m_rr     = (m_grant + 1) % NE;
            end else begin
                m_ov = 1'b0;
            end
        end
        if (inc != dec) begin
            if (inc >= 0 && m_cnt[inc] < CMAX) m_cnt[inc]++;
            if (dec >= 0) m_cnt[dec]--;
        end
        m_err = cur_rv && (cur_tid >= NE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NE-1:0] rev;
        bit            rdy, rv;
        logic [5:0]    rtid;

        rst_ni               = 1'b0;
        engine_req_valid_i   = '0;
        hpdcache_req_ready_i = 1'b0;
        hpdcache_rsp_valid_i = 1'b0;
        hpdcache_rsp_i       = '0;
        for (int i = 0; i < NE; i++) begin
            ereq_next[i] = rand_req();
            ereq_drv[i]  = ereq_next[i];
        end
        model_reset();
        #3;
        chk("reset_req_valid", 64'(hpdcache_req_valid_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_engine_ready", 64'(engine_req_ready_o), 64'd0);
        chk("reset_engine_rsp_valid", 64'(engine_rsp_valid_o), 64'd0);
        chk("reset_tid_err", 64'(rsp_tid_err_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        //            ev   rdy rv tid  erdy  qv qtid ersp  busy err
        tbl[0]  = v(4'b1111, 1, 0, 0, 4'b0001, 0, 0, 4'b0000, 0, 0);
        tbl[1]  = v(4'b1111, 1, 0, 0, 4'b0010, 1, 0, 4'b0000, 1, 0);
        tbl[2]  = v(4'b1111, 1, 0, 0, 4'b0100, 1, 1, 4'b0000, 1, 0);
        tbl[3]  = v(4'b1111, 1, 0, 0, 4'b1000, 1, 2, 4'b0000, 1, 0);
        tbl[4]  = v(4'b1111, 1, 0, 0, 4'b0001, 1, 3, 4'b0000, 1, 0);
        tbl[5]  = v(4'b0000, 1, 0, 0, 4'b0000, 1, 0, 4'b0000, 1, 0);
        tbl[6]  = v(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0);
        tbl[7]  = v(4'b0000, 1, 1, 0, 4'b0000, 0, 0, 4'b0001, 1, 0);
        tbl[8]  = v(4'b0000, 1, 1, 0, 4'b0000, 0, 0, 4'b0001, 1, 0);
        tbl[9]  = v(4'b0000, 1, 1, 1, 4'b0000, 0, 0, 4'b0010, 1, 0);
        tbl[10] = v(4'b0000, 1, 1, 2, 4'b0000, 0, 0, 4'b0100, 1, 0);
        tbl[11] = v(4'b0000, 1, 1, 3, 4'b0000, 0, 0, 4'b1000, 1, 0);
        tbl[12] = v(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0);
        tbl[13] = v(4'b0000, 1, 1, 7, 4'b0000, 0, 0, 4'b0000, 0, 0);
        tbl[14] = v(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 1);
        tbl[15] = v(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0);
        tbl[16] = v(4'b0100, 0, 0, 0, 4'b0100, 0, 0, 4'b0000, 0, 0);
        tbl[17] = v(4'b0100, 0, 0, 0, 4'b0000, 1, 2, 4'b0000, 1, 0);
        tbl[18] = v(4'b0100, 0, 0, 0, 4'b0000, 1, 2, 4'b0000, 1, 0);
        tbl[19] = v(4'b0100, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 1, 0);
        tbl[20] = v(4'b0100, 1, 0, 0, 4'b0000, 1, 2, 4'b0000, 1, 0);
        tbl[21] = v(4'b0100, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0);
        tbl[22] = v(4'b0100, 1, 1, 2, 4'b0000, 0, 0, 4'b0100, 1, 0);
        tbl[23] = v(4'b0100, 1, 0, 0, 4'b0100, 0, 0, 4'b0000, 1, 0);
        tbl[24] = v(4'b0001, 1, 0, 0, 4'b0001, 1, 2, 4'b0000, 1, 0);
        tbl[25] = v(4'b0001, 1, 1, 0, 4'b0001, 1, 0, 4'b0001, 1, 0);
        tbl[26] = v(4'b0001, 1, 0, 0, 4'b0001, 1, 0, 4'b0000, 1, 0);
        tbl[27] = v(4'b0001, 1, 0, 0, 4'b0000, 1, 0, 4'b0000, 1, 0);
        tbl[28] = v(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0);
        tbl[29] = v(4'b1010, 1, 0, 0, 4'b0010, 0, 0, 4'b0000, 1, 0);
        tbl[30] = v(4'b1010, 1, 0, 0, 4'b1000, 1, 1, 4'b0000, 1, 0);
        tbl[31] = v(4'b0010, 1, 0, 0, 4'b0010, 1, 3, 4'b0000, 1, 0);
        tbl[32] = v(4'b1010, 1, 0, 0, 4'b1000, 1, 1, 4'b0000, 1, 0);
        tbl[33] = v(4'b1010, 1, 0, 0, 4'b0000, 1, 3, 4'b0000, 1, 0);
        tbl[34] = v(4'b1010, 1, 1, 1, 4'b0000, 0, 0, 4'b0010, 1, 0);
        tbl[35] = v(4'b1010, 1, 0, 0, 4'b0010, 0, 0, 4'b0000, 1, 0);
        tbl[36] = v(4'b0000, 1, 0, 0, 4'b0000, 1, 1, 4'b0000, 1, 0);

        for (int r = 0; r < 37; r++) begin
            drive_and_check(tbl[r].ev, tbl[r].rdy, tbl[r].rv, tbl[r].rtid);
            chk($sformatf("tbl%0d_erdy", r), 64'(engine_req_ready_o), 64'(tbl[r].erdy));
            chk($sformatf("tbl%0d_qvalid", r), 64'(hpdcache_req_valid_o), 64'(tbl[r].qv));
            if (tbl[r].qv) chk($sformatf("tbl%0d_qtid", r), 64'(hpdcache_req_o.tid), 64'(tbl[r].qtid));
            chk($sformatf("tbl%0d_ersp", r), 64'(engine_rsp_valid_o), 64'(tbl[r].ersp));
            chk($sformatf("tbl%0d_busy", r), 64'(busy_o), 64'(tbl[r].busy));
            chk($sformatf("tbl%0d_err", r), 64'(rsp_tid_err_o), 64'(tbl[r].err));
            commit();
        end

        // Randomized traffic: engines hold a request until it is accepted.
        rev = '0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NE; i++) begin
                if (!rev[i] && $urandom_range(2) == 0) begin
                    rev[i]       = 1'b1;
                    ereq_next[i] = rand_req();
                end
            end
            rdy = ($urandom_range(3) != 0);
            rv  = 1'($urandom);
            if ($urandom_range(9) == 0) rtid = 6'($urandom_range(63, NE));
            else                        rtid = 6'($urandom_range(NE - 1));
            drive_and_check(rev, rdy, rv, rtid);
            commit();
            rev = rev & ~acc;
        end

        // Drain everything, then fill the buffer and some counters before a reset.
        for (int k = 0; k < 2 * NE; k++) begin
            drive_and_check('0, 1'b1, 1'b1, 6'(k % NE));
            commit();
        end
        for (int k = 0; k < 4; k++) begin
            drive_and_check(4'b1111, (k < 3), 1'b0, 6'd0);
            commit();
        end
        chk("prereset_busy", 64'(busy_o), 64'd1);
        chk("prereset_req_valid", 64'(hpdcache_req_valid_o), 64'd1);
        #1;
        engine_req_valid_i   = '0;
        hpdcache_rsp_valid_i = 1'b0;
        rst_ni               = 1'b0;
        #1;
        chk("midreset_req_valid", 64'(hpdcache_req_valid_o), 64'd0);
        chk("midreset_busy", 64'(busy_o), 64'd0);
        chk("midreset_engine_ready", 64'(engine_req_ready_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        drive_and_check(4'b1111, 1'b1, 1'b1, 6'd2);
        chk("postreset_first_grant", 64'(engine_req_ready_o), 64'b0001);
        commit();
        drive_and_check(4'b0000, 1'b1, 1'b0, 6'd0);
        chk("postreset_req_tid", 64'(hpdcache_req_o.tid), 64'd0);
        commit();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hwpf_stride_arb.md
Name: hwpf_stride_arb

Overview:
- Shares the single HPDcache request/response port among NUM_ENGINES stride prefetcher engines.
- Arbitrates engine requests round-robin and forwards one per cycle through a one-entry output register.
- Tags each forwarded request's tid with the engine index, and routes each response back to its engine by tid.
- Enforces an optional per-engine limit on outstanding prefetches. Sits between the engine array and the dcache prefetch requester port.

Parameters:
- NUM_ENGINES, 4, number of prefetch engines sharing the port (1..16).
- MAX_INFLIGHT, 0, maximum outstanding requests per engine; 0 means no limit.
- CNT_WIDTH, 8, width of each per-engine outstanding counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- engine_req_valid_i  in  NUM_ENGINES  per-engine request valid.
- engine_req_ready_o  out  NUM_ENGINES  per-engine request accepted.
- engine_req_i  in  NUM_ENGINES x hpdcache_req_t  per-engine request.
- engine_rsp_valid_o  out  NUM_ENGINES  per-engine response valid.
- engine_rsp_o  out  hpdcache_rsp_t  response payload, broadcast to all engines.
- hpdcache_req_valid_o  out  1  dcache request valid.
- hpdcache_req_ready_i  in  1  dcache request ready.
- hpdcache_req_o  out  hpdcache_req_t  dcache request.
- hpdcache_rsp_valid_i  in  1  dcache response valid.
- hpdcache_rsp_i  in  hpdcache_rsp_t  dcache response.
- busy_o  out  1  any request buffered or outstanding.
- rsp_tid_err_o  out  1  registered one-cycle pulse: a response arrived with tid >= NUM_ENGINES.

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset state: output buffer empty, rr_ptr=0, all counters 0, rsp_tid_err_o=0. Outputs: hpdcache_req_valid_o=0, busy_o=0, all engine_req_ready_o=0, all engine_rsp_valid_o=0.
- Output buffer (obuf) load condition: load_en = !obuf_valid || hpdcache_req_ready_i.
- Eligibility: eligible[i] = engine_req_valid_i[i] && (MAX_INFLIGHT==0 || cnt[i] < MAX_INFLIGHT).
- Grant: the first eligible index at or after rr_ptr, wrapping modulo NUM_ENGINES. Single grant only.
- Ready: engine_req_ready_o[i] = grant[i] && load_en, combinational.
- Handshake rule: engines must not make valid depend on ready. A request, once raised, stays stable until accepted.
- On accept from engine g:
  - obuf <= engine_req_i[g], with tid field = g zero-extended. All other fields pass through unchanged.
  - obuf_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_ENGINES.
- If load_en and no grant: obuf_valid <= 0 when drained.
- Latency: accepted at cycle N, visible on hpdcache_req_o at cycle N+1. Sustained throughput 1 request/cycle with ready held high.
- hpdcache_req_o / hpdcache_req_valid_o are driven directly from obuf. They stay stable while valid && !ready.
- Counters:
  - cnt[g]++ on engine accept.
  - cnt[t]-- on hpdcache_rsp_valid_i with rsp.tid==t < NUM_ENGINES.
  - Simultaneous inc and dec on the same engine: no change.
  - Decrement at 0 is ignored (no underflow). Increment saturates at 2^CNT_WIDTH-1.
- Response routing: engine_rsp_valid_o[i] = hpdcache_rsp_valid_i && rsp.tid==i, combinational. engine_rsp_o = hpdcache_rsp_i.
- tid >= NUM_ENGINES: response dropped, no counter changes; rsp_tid_err_o pulses high the next cycle.
- busy_o = obuf_valid || any cnt != 0, combinational from state.
- Reset mid-operation: buffered request discarded and counters cleared. Late responses after reset hit cnt=0 and are ignored per the underflow rule.
- Elaboration checks: $clog2(NUM_ENGINES) <= HPDCACHE_REQ_TRANS_ID_WIDTH, and MAX_INFLIGHT < 2^CNT_WIDTH.

Decomposition:
- hwpf_stride_pkg: HWPF_STRIDE_MAX_ENGINES=16 and hwpf_engine_id_t (4-bit).
- hpdcache_pkg: reuse hpdcache_req_t, hpdcache_rsp_t and the tid width.
- Sub-module hwpf_stride_rr_arb: N-input round-robin priority arbiter with one-hot grant, grant index out, and pointer update on accept. Instantiated once.

Test Plan:
- Engines 0..3 all valid, ready=1 constantly -> accepted order 0,1,2,3,0; output tids 0,1,2,3,0; one request per cycle; first output one cycle after the first accept.
- Engine 2 valid, hpdcache_req_ready_i=0 for 3 cycles -> req_o held stable with tid=2; engine_req_ready_o[2]=0 while obuf is full; drains on the cycle ready rises.
- MAX_INFLIGHT=2, engine 1 issues 2 requests, no responses -> engine 1 ineligible, engine 3 still granted; a rsp with tid=1 re-enables engine 1 the next cycle.
- Same-cycle accept for engine 0 and rsp tid=0 with cnt[0]=1 -> cnt[0] stays 1; engine_rsp_valid_o=4'b0001.
- rsp_valid with tid=7, NUM_ENGINES=4 -> no engine_rsp_valid_o asserted; rsp_tid_err_o=1 for exactly one cycle; counters unchanged.
- Assert rst_ni low with obuf full and cnt=3 -> hpdcache_req_valid_o=0 and busy_o=0 immediately; after release, rr_ptr=0 and engine 0 wins the first tie.
